// File: rtl/mem_pkg.sv
// Shared types and helpers for the RV32I data memory: access encodings,
// legality check and load extension.
package mem_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NLANES = 4;

  // Load encodings; SB/SH/SW reuse the 000/001/010 values.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

  function automatic logic f_legal(input logic we, input logic [2:0] funct3,
                                   input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (funct3)
      LB:      ok = 1'b1;
      LH:      ok = ~off[0];
      LW:      ok = (off == 2'b00);
      LBU:     ok = ~we;
      LHU:     ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [XLEN-1:0] f_load_ext(input logic [XLEN-1:0] word,
                                                 input logic [1:0] off,
                                                 input logic [2:0] funct3);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    r = '0;
    case (funct3)
      LB:      r = {{24{b[7]}}, b};
      LH:      r = {{16{h[15]}}, h};
      LW:      r = word;
      LBU:     r = {24'h0, b};
      LHU:     r = {16'h0, h};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/be_sram.sv
// Single-port word RAM with per-byte write enables and a registered read.
// The array itself is not reset; the controller zero-fills it.
module be_sram #(
  parameter  int unsigned DEPTH = 256,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // An enabled access with no byte enables is a read.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (be_i == 4'b0000) begin
        rdata_q <= mem_q[addr_i];
      end
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// RV32I MEM-stage data memory: zero-fill after reset, byte/half/word
// stores and extended loads behind a valid/ready request and held response.
module data_mem_ctrl #(
  parameter  int unsigned DEPTH = 256,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_busy
);

  import mem_pkg::*;

  ctrl_state_e   state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          init_busy_q, init_busy_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_load_q, rsp_load_d;
  logic [2:0]    rsp_funct3_q, rsp_funct3_d;
  logic [1:0]    rsp_off_q, rsp_off_d;

  logic          accept;
  logic          legal;
  logic [AW-1:0] req_word;
  logic [3:0]    st_be;
  logic [31:0]   st_data;
  logic          sram_en;
  logic [3:0]    sram_be;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;
  logic          addr_hi_unused;

  // Upper address bits only alias the array.
  assign addr_hi_unused = ^req_addr[31:AW+2];

  assign req_word  = req_addr[AW+1:2];
  assign legal     = f_legal(req_we, req_funct3, req_addr[1:0]);
  assign req_ready = (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;

  // Replicate store data across lanes; byte enables pick the live ones.
  always_comb begin
    st_be   = 4'b1111;
    st_data = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << req_addr[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = req_wdata;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    init_busy_d  = init_busy_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp_load_d   = rsp_load_q;
    rsp_funct3_d = rsp_funct3_q;
    rsp_off_d    = rsp_off_q;
    sram_en      = 1'b0;
    sram_be      = 4'b0000;
    sram_addr    = req_word;
    sram_wdata   = '0;

    case (state_q)
      ST_INIT: begin
        sram_en    = 1'b1;
        sram_be    = 4'b1111;
        sram_addr  = clr_cnt_q;
        sram_wdata = '0;
        clr_cnt_d  = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d     = ST_RUN;
          init_busy_d = 1'b0;
        end
      end
      ST_RUN: begin
        init_busy_d = 1'b0;
        if (accept) begin
          rsp_valid_d  = 1'b1;
          rsp_err_d    = !legal;
          rsp_load_d   = !req_we;
          rsp_funct3_d = req_funct3;
          rsp_off_d    = req_addr[1:0];
          if (legal) begin
            sram_en = 1'b1;
            if (req_we) begin
              sram_be    = st_be;
              sram_wdata = st_data;
            end
          end
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_load_d  = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      clr_cnt_q    <= '0;
      init_busy_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_load_q   <= 1'b0;
      rsp_funct3_q <= '0;
      rsp_off_q    <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      init_busy_q  <= init_busy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_load_q   <= rsp_load_d;
      rsp_funct3_q <= rsp_funct3_d;
      rsp_off_q    <= rsp_off_d;
    end
  end

  be_sram #(.DEPTH(DEPTH)) u_sram (
    .clk     (clk),
    .en_i    (sram_en),
    .be_i    (sram_be),
    .addr_i  (sram_addr),
    .wdata_i (sram_wdata),
    .rdata_o (sram_rdata)
  );

  // The RAM read register only updates on an accepted load, so it holds while stalled.
  assign rsp_rdata = (rsp_load_q && !rsp_err_q) ?
                     f_load_ext(sram_rdata, rsp_off_q, rsp_funct3_q) : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign init_busy = init_busy_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: expected responses are queued at
// request acceptance and compared when the response handshake occurs.
module tb_data_mem_ctrl;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_busy;

  int          checks   = 0;
  int          failures = 0;
  logic        mon_en   = 1'b0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_v;

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .init_busy  (init_busy)
  );

  // Response monitor: every consumed response is checked against the scoreboard.
  always @(negedge clk) begin
    if (mon_en && !reset && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got err=%0b rdata=%08h, required no response",
                 rsp_err, rsp_rdata);
      end else begin
        exp_v = exp_q.pop_front();
        if ({rsp_err, rsp_rdata} !== exp_v) begin
          failures++;
          $display("FAIL rsp_data: got err=%0b rdata=%08h, required err=%0b rdata=%08h",
                   rsp_err, rsp_rdata, exp_v[32], exp_v[31:0]);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    int n;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout: req_ready=%0b required 1 (addr=%08h)", req_ready, addr);
    end else begin
      exp_q.push_back({exp_err, exp_rd});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int cnt;
    int bad;
    reset      = 1'b1;
    rsp_ready  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = F_W;
    req_addr   = 32'h40;
    req_wdata  = 32'h0;
    req_valid  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
        init_busy !== 1'b1 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: got v=%0b d=%08h e=%0b busy=%0b rdy=%0b, required 0 0 0 1 0",
               rsp_valid, rsp_rdata, rsp_err, init_busy, req_ready);
    end
    cnt = 0;
    bad = 0;
    while (init_busy === 1'b1 && cnt < 1000) begin
      if (req_ready !== 1'b0) bad++;
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 256) begin
      failures++;
      $display("FAIL init_cycles: got %0d busy cycles, required 256", cnt);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL init_ready: req_ready high in %0d busy cycles, required 0", bad);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL run_ready: got req_ready=%0b after init, required 1", req_ready);
    end else begin
      exp_q.push_back({1'b0, 32'h0});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    drain();
  endtask

  task automatic test_load_ext;
    send(1'b1, F_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    send(1'b0, F_B,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0);
    send(1'b0, F_BU, 32'h13, 32'h0,        32'h000000DE, 1'b0);
    send(1'b0, F_H,  32'h10, 32'h0,        32'hFFFFBEEF, 1'b0);
    send(1'b0, F_HU, 32'h12, 32'h0,        32'h0000DEAD, 1'b0);
    send(1'b0, F_B,  32'h10, 32'h0,        32'hFFFFFFEF, 1'b0);
    drain();
  endtask

  task automatic test_store_lanes;
    send(1'b1, F_W, 32'h20, 32'h11223344, 32'h0, 1'b0);
    send(1'b1, F_B, 32'h21, 32'h123456AA, 32'h0, 1'b0);
    send(1'b1, F_H, 32'h22, 32'h99995566, 32'h0, 1'b0);
    send(1'b0, F_W, 32'h20, 32'h0,        32'h5566AA44, 1'b0);
    drain();
  endtask

  task automatic test_errors;
    send(1'b1, F_H,    32'h31, 32'hFFFFFFFF, 32'h0, 1'b1);
    send(1'b1, F_W,    32'h22, 32'h00000000, 32'h0, 1'b1);
    send(1'b0, F_W,    32'h23, 32'h0,        32'h0, 1'b1);
    send(1'b0, 3'b011, 32'h20, 32'h0,        32'h0, 1'b1);
    send(1'b1, F_BU,   32'h20, 32'h000000FF, 32'h0, 1'b1);
    send(1'b0, F_HU,   32'h21, 32'h0,        32'h0, 1'b1);
    send(1'b0, F_W,    32'h20, 32'h0,        32'h5566AA44, 1'b0);
    drain();
  endtask

  task automatic test_stall;
    rsp_ready = 1'b0;
    send(1'b0, F_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    req_we     = 1'b0;
    req_funct3 = F_W;
    req_addr   = 32'h20;
    req_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 ||
          req_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got v=%0b d=%08h e=%0b rdy=%0b, required 1 deadbeef 0 0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: got req_ready=%0b, required 1", req_ready);
    end else begin
      exp_q.push_back({1'b0, 32'h5566AA44});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back;
    send(1'b1, F_W, 32'h30, 32'h0BADCAFE, 32'h0,        1'b0);
    send(1'b0, F_W, 32'h30, 32'h0,        32'h0BADCAFE, 1'b0);
    send(1'b1, F_B, 32'h33, 32'h00000077, 32'h0,        1'b0);
    send(1'b0, F_W, 32'h30, 32'h0,        32'h77ADCAFE, 1'b0);
    drain();
  endtask

  task automatic test_stream;
    logic [31:0] s_addr [8];
    logic [2:0]  s_f3   [8];
    logic [31:0] s_exp  [8];
    time         t0;
    s_addr = '{32'h400, 32'h10, 32'h20, 32'h410, 32'h13, 32'h0, 32'h12, 32'h21};
    s_f3   = '{F_W, F_W, F_W, F_W, F_BU, F_W, F_H, F_BU};
    s_exp  = '{32'hCAFEF00D, 32'hDEADBEEF, 32'h5566AA44, 32'hDEADBEEF,
               32'h000000DE, 32'hCAFEF00D, 32'hFFFFDEAD, 32'h000000AA};
    send(1'b1, F_W, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0);
    t0 = $time;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, s_f3[i], s_addr[i], 32'h0, s_exp[i], 1'b0);
    end
    checks++;
    if (($time - t0) != 80) begin
      failures++;
      $display("FAIL stream_rate: 8 loads took %0t, required 80", $time - t0);
    end
    drain();
  endtask

  task automatic test_reset_mid;
    int n;
    rsp_ready = 1'b0;
    send(1'b0, F_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || init_busy !== 1'b1 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: got v=%0b d=%08h busy=%0b rdy=%0b, required 0 0 1 0",
               rsp_valid, rsp_rdata, init_busy, req_ready);
    end
    rsp_ready = 1'b1;
    n = 0;
    while (init_busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (init_busy !== 1'b0) begin
      failures++;
      $display("FAIL reinit_timeout: init_busy=%0b, required 0", init_busy);
    end
    @(posedge clk);
    #1;
    send(1'b0, F_W, 32'h10, 32'h0, 32'h0, 1'b0);
    send(1'b0, F_W, 32'h0,  32'h0, 32'h0, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_store_lanes();
    test_errors();
    test_stall();
    test_back_to_back();
    test_stream();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_queue: %0d outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
